// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache, one 32-bit word per line, between IF and the memory controller.
// Optional ICACHE_PERF_EN adds hit_count/miss_count ports and counters.
module icache #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_wrong,
  input  logic              icache_enable,
  input  logic [ADDR_W-1:0] pc_to_fetch,
  output logic [31:0]       instr_fetched,
  output logic              icache_success,
  output logic              mc_req,
  output logic [ADDR_W-1:0] mc_addr,
  input  logic [31:0]       mc_data,
  input  logic              mc_done
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [1:0] {S_IDLE, S_MISS, S_RESP} state_e;

  state_e              state_q;
  logic [LINES-1:0]    valid_q;
  logic                flush_q;
  logic [31:0]         instr_q;
  logic                succ_q;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic                  fill_en;
  logic                  unused_pc_lsb;

  assign pc_idx        = pc_to_fetch[INDEX_BITS+1:2];
  assign pc_tag        = pc_to_fetch[ADDR_W-1:INDEX_BITS+2];
  assign fill_idx      = addr_q[INDEX_BITS+1:2];
  assign fill_tag      = addr_q[ADDR_W-1:INDEX_BITS+2];
  assign hit           = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign fill_en       = rdy && (state_q == S_MISS) && mc_done;
  assign unused_pc_lsb = ^pc_to_fetch[1:0];

  // Tag/data storage carries no reset; valid_q alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mc_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      flush_q <= 1'b0;
      instr_q <= '0;
      succ_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (icache_enable && !jump_wrong) begin
            if (hit) begin
              instr_q <= data_q[pc_idx];
              succ_q  <= 1'b1;
              state_q <= S_RESP;
            end else begin
              req_q   <= 1'b1;
              addr_q  <= {pc_to_fetch[ADDR_W-1:2], 2'b00};
              state_q <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (mc_done) begin
            valid_q[fill_idx] <= 1'b1;
            req_q             <= 1'b0;
            if (!flush_q && !jump_wrong) begin
              succ_q  <= 1'b1;
              instr_q <= mc_data;
              state_q <= S_RESP;
            end else begin
              flush_q <= 1'b0;
              state_q <= S_IDLE;
            end
          end else if (jump_wrong) begin
            flush_q <= 1'b1;
          end
        end
        S_RESP: begin
          succ_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy && (state_q == S_IDLE) && icache_enable && !jump_wrong) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  assign instr_fetched  = instr_q;
  assign icache_success = succ_q;
  assign mc_req         = req_q;
  assign mc_addr        = addr_q;

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache against a transaction-level cache/memory model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        jump_wrong = 1'b0;
  logic        icache_enable = 1'b0;
  logic [31:0] pc_to_fetch = '0;
  logic [31:0] instr_fetched;
  logic        icache_success;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic [31:0] mc_data = '0;
  logic        mc_done = 1'b0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  icache #(.ADDR_W(32), .INDEX_BITS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .jump_wrong     (jump_wrong),
    .icache_enable  (icache_enable),
    .pc_to_fetch    (pc_to_fetch),
    .instr_fetched  (instr_fetched),
    .icache_success (icache_success),
    .mc_req         (mc_req),
    .mc_addr        (mc_addr),
    .mc_data        (mc_data),
    .mc_done        (mc_done)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_hits = 0;
  int unsigned exp_miss = 0;

  // Reference model: what the cache should hold, indexed by line.
  bit          m_valid [256];
  logic [21:0] m_tag   [256];
  logic [31:0] m_data  [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0000_0513;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[9:2]] && (m_tag[pc[9:2]] == pc[31:10]);
  endfunction

  task automatic model_fill(input logic [31:0] pc);
    m_valid[pc[9:2]] = 1'b1;
    m_tag[pc[9:2]]   = pc[31:10];
    m_data[pc[9:2]]  = mem_word(pc);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch; on a miss the memory answers after lat idle cycles, optionally with a flush.
  task automatic fetch(input logic [31:0] pc, input bit flush, input int unsigned lat);
    bit          h;
    logic [31:0] w;
    h = model_hit(pc);
    w = mem_word(pc);
    @(negedge clk);
    icache_enable = 1'b1;
    pc_to_fetch   = pc;
    @(posedge clk); #1;
    if (h) begin
      exp_hits++;
      check("hit_success", {31'b0, icache_success}, 32'd1);
      check("hit_instr", instr_fetched, m_data[pc[9:2]]);
      check("hit_no_req", {31'b0, mc_req}, 32'd0);
      @(negedge clk);
      icache_enable = 1'b0;
      @(posedge clk); #1;
      check("hit_pulse_end", {31'b0, icache_success}, 32'd0);
      return;
    end
    exp_miss++;
    check("miss_no_success", {31'b0, icache_success}, 32'd0);
    check("miss_req", {31'b0, mc_req}, 32'd1);
    check("miss_addr", mc_addr, pc);
    @(negedge clk);
    icache_enable = 1'b0;
    for (int unsigned i = 0; i < lat; i++) begin
      jump_wrong = flush && (i == 0);
      @(posedge clk); #1;
      check("miss_req_held", {31'b0, mc_req}, 32'd1);
      check("miss_wait_nosucc", {31'b0, icache_success}, 32'd0);
      @(negedge clk);
    end
    jump_wrong = flush && (lat == 0);
    mc_done    = 1'b1;
    mc_data    = w;
    @(posedge clk); #1;
    check("fill_req_drop", {31'b0, mc_req}, 32'd0);
    check("fill_success", {31'b0, icache_success}, {31'b0, !flush});
    if (!flush) check("fill_instr", instr_fetched, w);
    @(negedge clk);
    mc_done    = 1'b0;
    jump_wrong = 1'b0;
    mc_data    = $urandom;
    model_fill(pc);
    @(posedge clk); #1;
    check("fill_after", {31'b0, icache_success}, 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_success", {31'b0, icache_success}, 32'd0);
    check("rst_req", {31'b0, mc_req}, 32'd0);
    check("rst_addr", mc_addr, 32'd0);
    check("rst_instr", instr_fetched, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    fetch(32'h10, 1'b0, 2);          // cold miss
    fetch(32'h10, 1'b0, 0);          // hit
    fetch(32'h410, 1'b0, 1);         // conflict evicts 0x10
    fetch(32'h10, 1'b0, 0);
    fetch(32'h20, 1'b1, 2);          // flushed miss still fills
    fetch(32'h20, 1'b0, 0);
    fetch(32'h24, 1'b1, 0);          // flush coincident with mc_done
    fetch(32'h24, 1'b0, 0);

    // rdy stall in MISS with mc_done held
    @(negedge clk);
    icache_enable = 1'b1;
    pc_to_fetch   = 32'h30;
    @(posedge clk); #1;
    check("stall_req", {31'b0, mc_req}, 32'd1);
    exp_miss++;
    @(negedge clk);
    icache_enable = 1'b0;
    rdy     = 1'b0;
    mc_done = 1'b1;
    mc_data = mem_word(32'h30);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_req_held", {31'b0, mc_req}, 32'd1);
      check("stall_nosucc", {31'b0, icache_success}, 32'd0);
    end
    @(negedge clk);
    rdy = 1'b1;
    @(posedge clk); #1;
    check("stall_done_succ", {31'b0, icache_success}, 32'd1);
    check("stall_done_instr", instr_fetched, mem_word(32'h30));
    check("stall_done_req", {31'b0, mc_req}, 32'd0);
    @(negedge clk);
    mc_done = 1'b0;
    model_fill(32'h30);
    fetch(32'h30, 1'b0, 0);

    // async reset mid-miss
    fetch(32'h10, 1'b0, 0);
    @(negedge clk);
    icache_enable = 1'b1;
    pc_to_fetch   = 32'h40;
    @(posedge clk); #1;
    check("arst_req_before", {31'b0, mc_req}, 32'd1);
    exp_miss++;
    icache_enable = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", {31'b0, mc_req}, 32'd0);
    check("arst_succ", {31'b0, icache_success}, 32'd0);
    check("arst_addr", mc_addr, 32'd0);
    model_clear();
`ifdef ICACHE_PERF_EN
    exp_hits = 0;
    exp_miss = 0;
`endif
    @(negedge clk);
    rst     = 1'b0;
    mc_done = 1'b1;
    mc_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("stray_done_req", {31'b0, mc_req}, 32'd0);
    check("stray_done_succ", {31'b0, icache_success}, 32'd0);
    @(negedge clk);
    mc_done = 1'b0;
    fetch(32'h10, 1'b0, 1);          // formerly cached line must miss

    // random mix over a small address pool to get hits, conflicts and flushes
    for (int n = 0; n < 80; n++) begin
      pc = {20'b0, 2'($urandom_range(3)), 5'b0, 3'($urandom_range(7)), 2'b00};
      fetch(pc, ($urandom_range(4) == 0), $urandom_range(3));
    end

`ifdef ICACHE_PERF_EN
    check("perf_hits", hit_count, exp_hits);
    check("perf_miss", miss_count, exp_miss);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
